motor_cmd_sched: RTL and testbench
==================================

# motor_cmd_sched

Upstream scheduler feeding the four ESC PWM interfaces. Takes signed speed requests from the flight controller, saturates them to the 11-bit ESC range, applies per-frame slew limiting and arming gating, and issues a single frame-aligned `wrt` pulse with stable `SPEED` values so every ESC restarts its PWM period on the same cycle.

## Interface
- `FRAME_CYC`, 1_000_000: frame period in clocks; legal range ≥ 12400, which exceeds the ESC max pulse of 6250 + 3·2047 cycles.
- `SLEW_MAX`, 64: maximum per-frame increase or decrease of each motor speed; legal 1..2047.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `arm` in 1: level; 1 = motors enabled.
- `req_vld` in 1: one-cycle strobe; captures all four requests.
- `spd_req0`..`spd_req3` in 14 each: signed speed requests.
- `SPEED0`..`SPEED3` out 11 each: speed to the ESC interfaces.
- `wrt` out 1: one-cycle pulse, once per frame.
- `sat` out 4: bit i = last captured request i was clamped.

## Operation
- Capture: when `req_vld` = 1, each request is saturated into its shadow register and the matching `sat` bit is set to 1 if the request was clamped, otherwise 0.
  - req < 0 → 0.
  - req > 2047 → 2047.
  - Otherwise req[10:0].
- Frame counter `fcnt`: 0..FRAME_CYC-1, free-running, wraps to 0. `tick` = (`fcnt` == FRAME_CYC-1).
- FSM states:
  - IDLE → SNAP on `tick`. SNAP is the tick cycle itself, not a separate cycle.
  - In the `tick` cycle, all four shadows are copied into target registers. If `arm` = 0, the targets are forced to 0.
  - CALC: 4 cycles, motor index m = 0..3. At the end of each cycle, `SPEED`m is updated.
  - WRT: 1 cycle, `wrt` = 1, then back to IDLE.
- Update rule for armed motors: d = target − cur, as a 12-bit signed value. cur_next = cur + clamp(d, −SLEW_MAX, +SLEW_MAX). The result is always within 0..2047 and never overflows.
- Disarm: if `arm` = 0 at snapshot, cur_next = 0 directly, with no slew-down.
- `SPEED`m is held constant from its CALC update through the WRT cycle and until the next frame's CALC.

## Timing
- Reset values: `SPEED0..3` = 0, `wrt` = 0, `sat` = 0, shadows = 0, `fcnt` = 0, state = IDLE.
- Reset dominates every other input in the same cycle.
- Cycle 0 is the first cycle with `rst` = 0. `tick` occurs in cycle FRAME_CYC-1, and `SPEED`m updates at the end of cycle FRAME_CYC+m.
  - `wrt` is high in cycle FRAME_CYC+4.
  - Thereafter `wrt` repeats exactly every FRAME_CYC cycles.
- Latency from `req_vld` to the ESC `wrt`: ≤ FRAME_CYC+5 cycles.
- `req_vld` in the same cycle as `tick`: the snapshot uses the old shadow. The new value applies from the next frame.
- `req_vld` during CALC or WRT: updates the shadow only. The current frame is unaffected.
- `arm` is sampled only at `tick`. Changes at any other time have no effect until the next tick.
- `rst` mid-CALC or at WRT: outputs take reset values on the next edge. No `wrt` is issued for the aborted frame, and the frame counter restarts at 0.

## Structure
- Package `motor_pkg`:
  - `NUM_MOT` = 4, `SPD_W` = 11, `REQ_W` = 14, `SPD_MAX` = 2047.
  - FSM state enum {IDLE, CALC, WRT}.
  - Typedef `spd_t` = logic [SPD_W-1:0].
- Sub-module `spd_slew`: combinational. Inputs `cur`, `target`, `arm`, `SLEW_MAX`; output `nxt`.
  - Instantiated once and time-multiplexed across the 4 CALC cycles by motor index.

## Test plan
All scenarios use FRAME_CYC = 12400 and SLEW_MAX = 64.
- Reset release with `arm` = 0, no requests → `wrt` pulses at cycles 12404, 24804, …; `SPEED0..3` = 0 throughout.
- `arm` = 1, `req_vld` with all requests = 1000 → `SPEED` = 64, 128, … 960 on frames 1–15, then 1000 on frame 16 and held after.
- Requests −5, 3000, 2047, 0 → targets 0, 2047, 2047, 0; `sat` = 4'b0011.
- Armed at `SPEED0` = 640, then `arm` dropped before `tick` → `SPEED0` = 0 at the next update, `wrt` still issued.
- `req_vld` (500) coincident with `tick`, previous shadow 200, starting from `SPEED0` = 200 → `SPEED0` stays 200 this frame, becomes 264 next frame.
- `rst` pulsed in the second CALC cycle → no `wrt` for that frame; all outputs 0; next `wrt` at 12404 cycles after `rst` falls.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types, widths and request-saturation helpers for the motor command scheduler.
package motor_pkg;
  localparam int NUM_MOT = 4;
  localparam int SPD_W   = 11;
  localparam int REQ_W   = 14;
  localparam int SPD_MAX = 2047;

  typedef enum logic [1:0] {IDLE, CALC, WRT} state_t;
  typedef logic [SPD_W-1:0] spd_t;

  // A request is clamped when negative or above the 11-bit range.
  function automatic logic req_clamped(input logic [REQ_W-1:0] r);
    return r[REQ_W-1] | (|r[REQ_W-2:SPD_W]);
  endfunction

  function automatic spd_t req_sat(input logic [REQ_W-1:0] r);
    if (r[REQ_W-1])              return '0;
    else if (|r[REQ_W-2:SPD_W])  return spd_t'(SPD_MAX);
    else                         return r[SPD_W-1:0];
  endfunction
endpackage

// File: rtl/spd_slew.sv
// Per-motor slew limiter: moves cur toward target by at most SLEW_MAX, or to 0 when disarmed.
module spd_slew
  import motor_pkg::*;
#(
  parameter int SLEW_MAX = 64
) (
  input  spd_t cur,
  input  spd_t target,
  input  logic arm,
  output spd_t nxt
);
  localparam logic signed [SPD_W:0] LIM = (SPD_W+1)'(SLEW_MAX);

  logic signed [SPD_W:0] d;
  logic signed [SPD_W:0] step;

  always_comb begin
    d = $signed({1'b0, target}) - $signed({1'b0, cur});
    if (d > LIM)       step = LIM;
    else if (d < -LIM) step = -LIM;
    else               step = d;
    // Modular 11-bit add is exact: the clamped result always lands in 0..SPD_MAX.
    nxt = arm ? cur + spd_t'(step) : '0;
  end
endmodule

// File: rtl/motor_cmd_sched.sv
// Frame-aligned scheduler: saturates requests into shadows, snapshots them at frame tick,
// slews the four speeds one motor per cycle, then pulses wrt once.
module motor_cmd_sched
  import motor_pkg::*;
#(
  parameter int FRAME_CYC = 1_000_000,
  parameter int SLEW_MAX  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    req_vld,
  input  logic signed [REQ_W-1:0] spd_req0,
  input  logic signed [REQ_W-1:0] spd_req1,
  input  logic signed [REQ_W-1:0] spd_req2,
  input  logic signed [REQ_W-1:0] spd_req3,
  output spd_t                    SPEED0,
  output spd_t                    SPEED1,
  output spd_t                    SPEED2,
  output spd_t                    SPEED3,
  output logic                    wrt,
  output logic [NUM_MOT-1:0]      sat
);
  localparam int FC_W = $clog2(FRAME_CYC);

  logic [NUM_MOT-1:0][REQ_W-1:0] req;
  logic [NUM_MOT-1:0][SPD_W-1:0] shadow, target, cur;
  logic [FC_W-1:0]               fcnt;
  logic                          tick, arm_snap;
  logic [1:0]                    idx;
  state_t                        state_q, state_d;
  spd_t                          nxt;

  assign req  = {spd_req3, spd_req2, spd_req1, spd_req0};
  assign tick = (fcnt == FC_W'(FRAME_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) fcnt <= '0;
    else             fcnt <= fcnt + FC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      sat    <= '0;
    end else if (req_vld) begin
      for (int i = 0; i < NUM_MOT; i++) begin
        shadow[i] <= req_sat(req[i]);
        sat[i]    <= req_clamped(req[i]);
      end
    end
  end

  // Snapshot reads the pre-edge shadow, so a coincident req_vld lands next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= '0;
      arm_snap <= 1'b0;
    end else if (state_q == IDLE && tick) begin
      target   <= arm ? shadow : '0;
      arm_snap <= arm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx     <= '0;
    end else begin
      state_q <= state_d;
      idx     <= (state_q == CALC) ? idx + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    wrt     = 1'b0;
    case (state_q)
      IDLE: if (tick) state_d = CALC;
      CALC: if (idx == 2'd3) state_d = WRT;
      WRT: begin
        wrt     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  spd_slew #(.SLEW_MAX(SLEW_MAX)) u_slew (
    .cur    (cur[idx]),
    .target (target[idx]),
    .arm    (arm_snap),
    .nxt    (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst)                   cur      <= '0;
    else if (state_q == CALC)  cur[idx] <= nxt;
  end

  assign SPEED0 = cur[0];
  assign SPEED1 = cur[1];
  assign SPEED2 = cur[2];
  assign SPEED3 = cur[3];
endmodule

// File: tb/tb_motor_cmd_sched.sv
// Bench for motor_cmd_sched: saturation table, directed frame sequences, and random
// request pulses checked against a frame-level reference model.
module tb_motor_cmd_sched;
  localparam int FC = 12400;
  localparam int SL = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arm = 1'b0;
  logic              req_vld = 1'b0;
  logic signed [13:0] req [4];
  logic [10:0]       spd [4];
  logic              wrt;
  logic [3:0]        sat;

  int  checks = 0;
  int  failures = 0;
  int  cnum = 0;
  bit  rnd_en = 1'b0;

  motor_cmd_sched #(.FRAME_CYC(FC), .SLEW_MAX(SL)) dut (
    .clk(clk), .rst(rst), .arm(arm), .req_vld(req_vld),
    .spd_req0(req[0]), .spd_req1(req[1]), .spd_req2(req[2]), .spd_req3(req[3]),
    .SPEED0(spd[0]), .SPEED1(spd[1]), .SPEED2(spd[2]), .SPEED3(spd[3]),
    .wrt(wrt), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int cyc, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Reference model: per-cycle bookkeeping driven only by the frame rules.
  int m_cyc, m_spd[4], m_sh[4], m_new[4];
  logic [3:0] m_sat;
  bit m_ok = 1'b0;

  always @(negedge clk) begin
    int ph, d, r;
    if (m_ok) begin
      ph = m_cyc % FC;
      if (m_cyc < 8 || ph <= 8 || ph >= FC - 4 || (m_cyc % 1000) == 0) begin
        check("model_wrt", m_cyc, int'(wrt), int'(m_cyc >= FC + 4 && ph == 4));
        for (int m = 0; m < 4; m++) check($sformatf("model_spd%0d", m), m_cyc, int'(spd[m]), m_spd[m]);
        check("model_sat", m_cyc, int'(sat), int'(m_sat));
      end
    end
    if (rst) begin
      m_ok = 1'b1; m_cyc = 0; m_sat = '0;
      for (int m = 0; m < 4; m++) begin m_spd[m] = 0; m_sh[m] = 0; m_new[m] = 0; end
    end else if (m_ok) begin
      ph = m_cyc % FC;
      if (m_cyc >= FC && ph < 4) m_spd[ph] = m_new[ph];
      if (ph == FC - 1)
        for (int m = 0; m < 4; m++) begin
          d = m_sh[m] - m_spd[m];
          if (d > SL) d = SL;
          if (d < -SL) d = -SL;
          m_new[m] = arm ? m_spd[m] + d : 0;
        end
      if (req_vld)
        for (int m = 0; m < 4; m++) begin
          r = req[m];
          m_sh[m]  = (r < 0) ? 0 : (r > 2047) ? 2047 : r;
          m_sat[m] = (r < 0) || (r > 2047);
        end
      m_cyc++;
    end
  end

  // Advance one cycle; inputs are set 1 time unit after the edge that starts the cycle.
  task automatic adv();
    @(posedge clk); #1;
    cnum++;
    req_vld = 1'b0;
    if (rnd_en && $urandom_range(0, 499) == 0) begin
      req_vld = 1'b1;
      for (int m = 1; m < 4; m++) req[m] = 14'($urandom_range(0, 16383));
    end
  endtask

  task automatic go_to(input int n);
    while (cnum < n) adv();
  endtask

  typedef struct { logic [3:0][13:0] r; logic [3:0] s; } vec_t;
  vec_t tbl [6];

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input logic [3:0] s);
    vec_t v;
    v.r[0] = 14'(a); v.r[1] = 14'(b); v.r[2] = 14'(c); v.r[3] = 14'(d); v.s = s;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(-5, 3000, 2047, 0, 4'b0011);
    tbl[1] = mk(0, 0, 0, 0, 4'b0000);
    tbl[2] = mk(-1, 2048, -8192, 8191, 4'b1111);
    tbl[3] = mk(2047, 2046, 1, -2048, 4'b1000);
    tbl[4] = mk(100, -100, 4000, 500, 4'b0110);
    tbl[5] = mk(2048, 2047, -1, 0, 4'b0101);
    for (int m = 0; m < 4; m++) req[m] = '0;

    repeat (3) adv();
    rst = 1'b0; cnum = 0;
    check("reset_wrt", cnum, int'(wrt), 0);
    check("reset_sat", cnum, int'(sat), 0);

    foreach (tbl[i]) begin
      for (int m = 0; m < 4; m++) req[m] = tbl[i].r[m];
      req_vld = 1'b1;
      adv();
      check($sformatf("tbl_sat%0d", i), cnum, int'(sat), int'(tbl[i].s));
    end

    req[0] = 14'sd0; req[1] = 14'sd1000; req[2] = 14'sd40; req[3] = 14'sd3000;
    req_vld = 1'b1;
    adv();
    rnd_en = 1'b1;

    // Frame 1, disarmed: wrt at FC+4, speeds zero.
    go_to(FC + 4);
    check("f1_wrt", cnum, int'(wrt), 1);
    for (int m = 0; m < 4; m++) check($sformatf("f1_spd%0d", m), cnum, int'(spd[m]), 0);
    adv();
    check("f1_wrt_pulse", cnum, int'(wrt), 0);
    arm = 1'b1;

    // New request on the tick itself: this frame still uses the old shadow (0).
    go_to(2 * FC - 1);
    req[0] = 14'sd500; req_vld = 1'b1;
    go_to(2 * FC + 4);
    check("coinc_hold", cnum, int'(spd[0]), 0);
    go_to(3 * FC + 4);
    check("coinc_next", cnum, int'(spd[0]), 64);

    // Disarm before tick: every motor drops straight to 0, wrt still issued.
    go_to(3 * FC + 100);
    arm = 1'b0;
    go_to(4 * FC + 4);
    check("disarm_wrt", cnum, int'(wrt), 1);
    for (int m = 0; m < 4; m++) check($sformatf("disarm_spd%0d", m), cnum, int'(spd[m]), 0);
    go_to(4 * FC + 100);
    arm = 1'b1;

    // Reset during the second CALC cycle aborts the frame.
    go_to(5 * FC + 1);
    check("pre_rst_spd0", cnum, int'(spd[0]), 64);
    rst = 1'b1;
    adv();
    rst = 1'b0; cnum = 0;
    check("rst_wrt", cnum, int'(wrt), 0);
    check("rst_sat", cnum, int'(sat), 0);
    for (int m = 0; m < 4; m++) check($sformatf("rst_spd%0d", m), cnum, int'(spd[m]), 0);
    go_to(4);
    check("aborted_wrt", cnum, int'(wrt), 0);
    go_to(FC + 4);
    check("post_rst_wrt", cnum, int'(wrt), 1);
    repeat (10) adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
